// File: rtl/pixel_addr_gen_if.sv
// pixel_addr_gen_if: pop-side bus of the raster address FIFO; iPAN_X exists only with PIXEL_ADDR_GEN_PAN_EN.
interface pixel_addr_gen_if #(
  parameter int ADDR_W     = 20,
  parameter int FIFO_DEPTH = 16
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  logic              iREAD;
  logic [1:0]        iMODE;
`ifdef PIXEL_ADDR_GEN_PAN_EN
  logic [ADDR_W-1:0] iPAN_X;
`endif
  logic [ADDR_W-1:0] oADDRESS;
  logic              oFRAME_SYNC;
  logic              oREADY_N;
  logic [LVL_W-1:0]  oLEVEL;
`ifdef PIXEL_ADDR_GEN_PAN_EN
  modport master (output iREAD, iMODE, iPAN_X, input oADDRESS, oFRAME_SYNC, oREADY_N, oLEVEL);
  modport slave  (input iREAD, iMODE, iPAN_X, output oADDRESS, oFRAME_SYNC, oREADY_N, oLEVEL);
`else
  modport master (output iREAD, iMODE, input oADDRESS, oFRAME_SYNC, oREADY_N, oLEVEL);
  modport slave  (input iREAD, iMODE, output oADDRESS, oFRAME_SYNC, oREADY_N, oLEVEL);
`endif
endinterface

// File: rtl/pixel_addr_gen.sv
// pixel_addr_gen: raster pixel counter mapped through flip/mirror modes into a show-ahead address FIFO.
// Optional horizontal pan enabled by PIXEL_ADDR_GEN_PAN_EN.
module pixel_addr_gen #(
  parameter int H_RES      = 800,
  parameter int V_RES      = 480,
  parameter int ADDR_W     = 20,
  parameter int FIFO_DEPTH = 16
) (
  input logic              CLK,
  input logic              RESET_N,
  pixel_addr_gen_if.slave  bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] H  = ADDR_W'(H_RES);
  localparam logic [ADDR_W-1:0] HM = ADDR_W'(H_RES - 1);
  localparam logic [ADDR_W-1:0] VM = ADDR_W'(V_RES - 1);
  localparam logic [LVL_W-1:0]  DEPTH = LVL_W'(FIFO_DEPTH);
  logic [ADDR_W-1:0] col, row, rr, cc, addr;
  logic [1:0]        mode;
  logic [LVL_W-1:0]  level;
  logic [PTR_W-1:0]  wptr, rptr;
  logic [ADDR_W:0]   mem [FIFO_DEPTH];
  logic              wr, rd, last, empty;
  always_comb begin
    empty = level == '0;
    wr    = level != DEPTH;
    rd    = bus.iREAD && !empty;
    last  = row == VM && col == HM;
    rr    = mode[0] ? VM - row : row;
    cc    = mode[1] ? HM - col : col;
  end
`ifdef PIXEL_ADDR_GEN_PAN_EN
  logic [ADDR_W-1:0] pan;
  logic [ADDR_W:0]   pc;
  always_comb begin
    pc   = {1'b0, cc} + {1'b0, pan};
    addr = rr * H + (pc >= {1'b0, H} ? ADDR_W'(pc - {1'b0, H}) : pc[ADDR_W-1:0]);
  end
  // out-of-range pan is dropped at latch time so the modulo above needs one subtraction only
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) pan <= '0;
    else if (wr && last) pan <= bus.iPAN_X >= H ? '0 : bus.iPAN_X;
`else
  assign addr = rr * H + cc;
`endif
  // mode is sampled on the last pixel's write so the next frame starts with it
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      col   <= '0;
      row   <= '0;
      mode  <= 2'd1;
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (wr) begin
        col  <= col == HM ? '0 : col + 1'b1;
        if (col == HM) row <= row == VM ? '0 : row + 1'b1;
        if (last) mode <= bus.iMODE;
        wptr <= wptr + 1'b1;
      end
      if (rd) rptr <= rptr + 1'b1;
      level <= level + LVL_W'(wr) - LVL_W'(rd);
    end
  always_ff @(posedge CLK)
    if (wr) mem[wptr] <= {row == '0 && col == '0, addr};
  assign bus.oADDRESS    = empty ? '0 : mem[rptr][ADDR_W-1:0];
  assign bus.oFRAME_SYNC = !empty && mem[rptr][ADDR_W];
  assign bus.oREADY_N    = empty;
  assign bus.oLEVEL      = level;
endmodule

// File: tb/tb_pixel_addr_gen.sv
// tb_pixel_addr_gen: default-size instance for reset/fill/full checks, small instance for whole-frame mode and random-read checks.
module tb_pixel_addr_gen;
  localparam int HS = 10, VS = 6, NS = HS * VS, AWS = 8, DS = 4;
  logic CLK = 0, RESET_N = 0;
  int errors = 0, checks = 0, nd = 0;
  int fm_s [0:7];
  pixel_addr_gen_if bus_d ();
  pixel_addr_gen_if #(.ADDR_W(AWS), .FIFO_DEPTH(DS)) bus_s ();
  pixel_addr_gen dut_d (.CLK(CLK), .RESET_N(RESET_N), .bus(bus_d));
  pixel_addr_gen #(.H_RES(HS), .V_RES(VS), .ADDR_W(AWS), .FIFO_DEPTH(DS)) dut_s (.CLK(CLK), .RESET_N(RESET_N), .bus(bus_s));
  always #5 CLK = ~CLK;

  function automatic int exp_d(int n);
    return (479 - n / 800) * 800 + n % 800;
  endfunction

  function automatic logic [AWS:0] exp_s(int n);
    int p = n % NS;
    int m = fm_s[n / NS];
    int r = p / HS;
    int c = p % HS;
    if (m[0]) r = VS - 1 - r;
    if (m[1]) c = HS - 1 - c;
    return {p == 0, AWS'(r * HS + c)};
  endfunction

  task automatic do_reset();
    @(negedge CLK); RESET_N = 0;
    @(negedge CLK); RESET_N = 1;
  endtask

  task automatic test_reset();
    @(negedge CLK); #1;
    checks++; if (bus_d.oREADY_N !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", bus_d.oREADY_N); end
    checks++; if (bus_d.oLEVEL !== 5'd0) begin errors++; $display("FAIL rst_level got=%0d exp=0", bus_d.oLEVEL); end
    checks++; if (bus_d.oADDRESS !== 20'd0) begin errors++; $display("FAIL rst_addr got=%0d exp=0", bus_d.oADDRESS); end
    checks++; if (bus_d.oFRAME_SYNC !== 1'b0) begin errors++; $display("FAIL rst_sync got=%b exp=0", bus_d.oFRAME_SYNC); end
    checks++; if (bus_s.oREADY_N !== 1'b1) begin errors++; $display("FAIL rst_ready_s got=%b exp=1", bus_s.oREADY_N); end
  endtask

  task automatic test_fill();
    @(negedge CLK); RESET_N = 1; #1;
    checks++; if (bus_d.oREADY_N !== 1'b1) begin errors++; $display("FAIL fill_ready_pre got=%b exp=1", bus_d.oREADY_N); end
    for (int k = 1; k <= 20; k++) begin
      @(posedge CLK); #1;
      checks++; if (bus_d.oLEVEL !== 5'(k < 16 ? k : 16)) begin errors++; $display("FAIL fill_level k=%0d got=%0d exp=%0d", k, bus_d.oLEVEL, k < 16 ? k : 16); end
      checks++; if (bus_d.oREADY_N !== 1'b0) begin errors++; $display("FAIL fill_ready k=%0d got=%b exp=0", k, bus_d.oREADY_N); end
    end
    checks++; if (bus_d.oADDRESS !== 20'd383200) begin errors++; $display("FAIL fill_head got=%0d exp=383200", bus_d.oADDRESS); end
    checks++; if (bus_d.oFRAME_SYNC !== 1'b1) begin errors++; $display("FAIL fill_sync got=%b exp=1", bus_d.oFRAME_SYNC); end
    checks++; if (bus_s.oLEVEL !== 3'd4) begin errors++; $display("FAIL fill_level_s got=%0d exp=4", bus_s.oLEVEL); end
    checks++; if ({bus_s.oFRAME_SYNC, bus_s.oADDRESS} !== {1'b1, 8'd50}) begin errors++; $display("FAIL fill_head_s got=%b/%0d exp=1/50", bus_s.oFRAME_SYNC, bus_s.oADDRESS); end
  endtask

  task automatic test_full_read();
    @(negedge CLK); bus_d.iREAD = 1; #1;
    checks++; if (bus_d.oADDRESS !== 20'(exp_d(0))) begin errors++; $display("FAIL full_pop0 got=%0d exp=%0d", bus_d.oADDRESS, exp_d(0)); end
    @(negedge CLK); bus_d.iREAD = 0; #1;
    checks++; if (bus_d.oLEVEL !== 5'd15) begin errors++; $display("FAIL full_level_after_pop got=%0d exp=15", bus_d.oLEVEL); end
    @(negedge CLK); #1;
    checks++; if (bus_d.oLEVEL !== 5'd16) begin errors++; $display("FAIL full_level_refill got=%0d exp=16", bus_d.oLEVEL); end
    nd = 1;
    for (int k = 0; k < 16; k++) begin
      @(negedge CLK); bus_d.iREAD = 1; #1;
      checks++; if ({bus_d.oFRAME_SYNC, bus_d.oADDRESS} !== {1'b0, 20'(exp_d(nd))}) begin errors++; $display("FAIL full_seq n=%0d got=%0d exp=%0d", nd, bus_d.oADDRESS, exp_d(nd)); end
      nd++;
    end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 3000 && nd < 1000; k++) begin
      @(negedge CLK); bus_d.iREAD = 1; #1;
      if (!bus_d.oREADY_N) begin
        checks++; if (bus_d.oADDRESS !== 20'(exp_d(nd))) begin errors++; $display("FAIL seq_d n=%0d got=%0d exp=%0d", nd, bus_d.oADDRESS, exp_d(nd)); end
        nd++;
      end
    end
    checks++; if (nd != 1000) begin errors++; $display("FAIL seq_d_timeout got=%0d exp=1000", nd); end
    @(posedge CLK); #3; RESET_N = 0; #1;
    checks++; if (bus_d.oREADY_N !== 1'b1) begin errors++; $display("FAIL arst_ready got=%b exp=1", bus_d.oREADY_N); end
    checks++; if (bus_d.oLEVEL !== 5'd0) begin errors++; $display("FAIL arst_level got=%0d exp=0", bus_d.oLEVEL); end
    checks++; if (bus_d.oADDRESS !== 20'd0) begin errors++; $display("FAIL arst_addr got=%0d exp=0", bus_d.oADDRESS); end
    @(negedge CLK); bus_d.iREAD = 0; RESET_N = 1;
    @(posedge CLK); #1;
    checks++; if (bus_d.oREADY_N !== 1'b0) begin errors++; $display("FAIL arst_ready_post got=%b exp=0", bus_d.oREADY_N); end
    checks++; if ({bus_d.oFRAME_SYNC, bus_d.oADDRESS} !== {1'b1, 20'd383200}) begin errors++; $display("FAIL arst_head got=%b/%0d exp=1/383200", bus_d.oFRAME_SYNC, bus_d.oADDRESS); end
  endtask

  task automatic test_modes();
    int ns = 0, lvl = 0, last_sync = -1;
    bus_s.iMODE = 0; bus_s.iREAD = 0;
    fm_s = '{1, 0, 2, 3, 3, 3, 3, 3};
    do_reset();
    for (int k = 0; k < 2000 && ns < 4 * NS; k++) begin
      bus_s.iMODE = ns < 70 ? 2'd0 : ns < 130 ? 2'd2 : 2'd3;
      bus_s.iREAD = 1; #1;
      checks++; if (bus_s.oLEVEL !== 3'(lvl) || bus_s.oREADY_N !== (lvl == 0)) begin errors++; $display("FAIL modes_level k=%0d got=%0d/%b exp=%0d", k, bus_s.oLEVEL, bus_s.oREADY_N, lvl); end
      if (lvl != 0) begin
        checks++; if ({bus_s.oFRAME_SYNC, bus_s.oADDRESS} !== exp_s(ns)) begin errors++; $display("FAIL modes_pop n=%0d got=%b/%0d exp=%b/%0d", ns, bus_s.oFRAME_SYNC, bus_s.oADDRESS, exp_s(ns) >> AWS, exp_s(ns) & 9'hff); end
        if (bus_s.oFRAME_SYNC) begin
          if (last_sync >= 0) begin checks++; if (ns - last_sync != NS) begin errors++; $display("FAIL sync_spacing got=%0d exp=%0d", ns - last_sync, NS); end end
          last_sync = ns;
        end
        ns++;
      end
      lvl = lvl + (lvl < DS ? 1 : 0) - (lvl != 0 ? 1 : 0);
      @(negedge CLK);
    end
    checks++; if (ns != 4 * NS) begin errors++; $display("FAIL modes_timeout got=%0d exp=%0d", ns, 4 * NS); end
  endtask

  task automatic test_random();
    for (int rep = 0; rep < 2; rep++) begin
      int ns = 0, lvl = 0;
      logic rd;
      logic [1:0] ma = 2'($urandom_range(0, 3)), mb = 2'($urandom_range(0, 3));
      fm_s = '{1, int'(ma), int'(mb), int'(mb), 0, 0, 0, 0};
      bus_s.iMODE = ma; bus_s.iREAD = 0;
      do_reset();
      for (int k = 0; k < 5000 && ns < 3 * NS; k++) begin
        bus_s.iMODE = ns < 70 ? ma : mb;
        rd = $urandom_range(0, 99) < 30;
        bus_s.iREAD = rd; #1;
        checks++; if (bus_s.oLEVEL !== 3'(lvl) || bus_s.oREADY_N !== (lvl == 0)) begin errors++; $display("FAIL rand_level k=%0d got=%0d/%b exp=%0d", k, bus_s.oLEVEL, bus_s.oREADY_N, lvl); end
        if (rd && lvl != 0) begin
          checks++; if ({bus_s.oFRAME_SYNC, bus_s.oADDRESS} !== exp_s(ns)) begin errors++; $display("FAIL rand_pop n=%0d got=%b/%0d exp=%b/%0d", ns, bus_s.oFRAME_SYNC, bus_s.oADDRESS, exp_s(ns) >> AWS, exp_s(ns) & 9'hff); end
          ns++;
        end
        lvl = lvl + (lvl < DS ? 1 : 0) - (rd && lvl != 0 ? 1 : 0);
        @(negedge CLK);
      end
      checks++; if (ns != 3 * NS) begin errors++; $display("FAIL rand_timeout got=%0d exp=%0d", ns, 3 * NS); end
    end
  endtask

  initial begin
    bus_d.iREAD = 0; bus_d.iMODE = 0;
    bus_s.iREAD = 0; bus_s.iMODE = 0;
`ifdef PIXEL_ADDR_GEN_PAN_EN
    bus_d.iPAN_X = 0; bus_s.iPAN_X = 0;
`endif
    test_reset();
    test_fill();
    test_full_read();
    test_async_reset();
    test_modes();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
